pwm_code_writer: RTL and testbench
==================================

Name: pwm_code_writer

Overview:
- ACLK-domain producer for the PWM code buffer.
- Accepts 4-bit PWM duty codes from the delta-sigma modulator over a valid/ready handshake and clamps them to the legal range.
- Stages codes in a small local FIFO and writes them into the cross-clock PWM FIFO only while that FIFO's write-ready (pwmBUF_WREADY) is high.
- Handles start-up priming with mid-scale codes, mute substitution, and an orderly drain on stop.

Parameters:
- DEPTH, 4, staging FIFO entries; power of 2, at least 2.
- MAX_CODE, 12, largest legal duty code (12-slot PWM frame).
- MID_CODE, 6, silence code used for priming and mute.
- PRIME_CNT, 256, number of MID_CODE writes issued before RUN; range 1..65535.

Ports:
- ACLK, in, 1, sole clock.
- ARSTN, in, 1, reset; asynchronous, active-low.
- en, in, 1, play enable (level).
- mute, in, 1, substitute MID_CODE at write time (level).
- clr_stat, in, 1, single-cycle pulse; clears clamp_cnt.
- s_valid, in, 1, modulator code valid.
- s_data, in, 4, modulator duty code.
- s_ready, out, 1, writer accepts s_data this cycle.
- pwmBUF_WREADY, in, 1, PWM FIFO has room (level).
- pwmBUF_WR, out, 1, PWM FIFO write strobe, registered.
- pwmBUF_DIN, out, 4, PWM FIFO write data, registered.
- state, out, 2, 0=IDLE, 1=PRIME, 2=RUN, 3=DRAIN.
- fill, out, log2(DEPTH)+1, staging occupancy.
- clamp_cnt, out, 16, saturating count of clamped inputs.

Behaviour:
- Reset (ARSTN=0, async): state=IDLE, staging empty, fill=0, prime counter=0, pwmBUF_WR=0, pwmBUF_DIN=0, s_ready=0, clamp_cnt=0. Asserting reset mid-operation discards staged codes. No write strobe appears in the cycle after ARSTN releases.
- Issue decision (cycle N) -> pwmBUF_WR=1 with pwmBUF_DIN valid in cycle N+1; fixed 1-cycle latency.
  - At most one write per cycle.
  - pwmBUF_WREADY is sampled in the decision cycle only.
  - If no issue occurs, pwmBUF_WR=0 and pwmBUF_DIN holds its last value.
- s_ready = (state==RUN) && (fill<DEPTH); combinational from registered state.
- Push (s_valid & s_ready):
  - Stored code = min(s_data, MAX_CODE).
  - If s_data > MAX_CODE, clamp_cnt increments, saturating at 0xFFFF.
  - clr_stat in the same cycle as a clamp gives clamp_cnt=0 (clear wins).
- Pop: occurs when state is RUN or DRAIN, fill>0, and pwmBUF_WREADY=1.
  - Issued data = mute ? MID_CODE : head entry; mute is sampled in the pop cycle.
  - The head is consumed even when muted.
- Push and pop in the same cycle: fill unchanged. Read and write pointers wrap modulo DEPTH.
- IDLE: no writes; s_ready=0. en=1 -> PRIME next cycle, prime counter cleared.
- PRIME:
  - Each cycle with pwmBUF_WREADY=1 issues MID_CODE (mute is irrelevant) and increments the prime counter.
  - When the PRIME_CNT-th write issues -> RUN next cycle.
  - en=0 -> IDLE next cycle; writes already issued complete; no further prime writes.
- RUN: push and pop as above. en=0 -> DRAIN next cycle; s_ready drops that same cycle.
- DRAIN:
  - s_ready=0; pops continue until fill=0, then IDLE next cycle.
  - DRAIN entered with fill=0 -> IDLE next cycle.
  - en is ignored in DRAIN; if en=1 in IDLE, PRIME follows the cycle after.
- WREADY low for any duration: no pops; staging fills to DEPTH, then s_ready=0. Nothing is lost or duplicated.
- Staging empty in RUN with pwmBUF_WREADY=1: no write. The writer never pads with MID_CODE outside PRIME.

Test Plan:
- Reset, en=1, WREADY=1 constant, PRIME_CNT=4 -> exactly 4 consecutive writes of 6; state=RUN in the cycle after the 4th issue; no extra strobe.
- RUN, stream 0,5,12,15,9 with WREADY=1 -> pwmBUF_DIN 0,5,12,12,9 in order; clamp_cnt=1; each write 1 cycle after pop.
- RUN, WREADY=0 for 20 cycles with s_valid=1 -> fill=4, s_ready=0, zero writes. WREADY=1 -> the 4 staged codes emerge in order, then streaming resumes.
- Toggle mute=1 for 3 pops in mid-stream -> those 3 writes carry 6; inputs consumed; the following writes resume with the correct next codes.
- en=0 with fill=3 and WREADY=1 -> 3 writes, state DRAIN then IDLE, s_ready=0 throughout. en=0 during PRIME after 2 writes -> IDLE, no further writes.
- Assert ARSTN=0 mid-RUN with fill=2 -> all outputs 0 asynchronously; after release, en=1 restarts PRIME from count 0; clamp_cnt=0.

Source files
------------

// File: rtl/pwm_code_writer.sv
// PWM code writer: clamps modulator codes, stages them, and feeds the
// cross-clock PWM FIFO with priming, mute and drain handling.
module pwm_code_writer #(
  parameter int DEPTH     = 4,
  parameter int MAX_CODE  = 12,
  parameter int MID_CODE  = 6,
  parameter int PRIME_CNT = 256
) (
  input  logic                     ACLK,
  input  logic                     ARSTN,
  input  logic                     en,
  input  logic                     mute,
  input  logic                     clr_stat,
  input  logic                     s_valid,
  input  logic [3:0]               s_data,
  output logic                     s_ready,
  input  logic                     pwmBUF_WREADY,
  output logic                     pwmBUF_WR,
  output logic [3:0]               pwmBUF_DIN,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [15:0]              clamp_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0]  MAXC  = 4'(MAX_CODE);
  localparam logic [3:0]  MIDC  = 4'(MID_CODE);
  localparam logic [15:0] PLAST = 16'(PRIME_CNT - 1);
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] F1    = (AW+1)'(1);
  localparam logic [AW-1:0] P1  = (AW)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } st_e;

  st_e           state_q;
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   fill_q;
  logic [3:0]    mem_q [DEPTH];
  logic [15:0]   pcnt_q;
  logic [15:0]   cc_q;
  logic          wr_q;
  logic [3:0]    din_q;

  logic          ready_d;
  logic          push_d;
  logic          pop_d;
  logic          prime_d;
  logic          clamp_d;
  logic [3:0]    code_d;

  // Handshake and issue decisions from registered state
  always_comb begin
    ready_d = (state_q == RUN) && (fill_q < FULL);
    push_d  = s_valid && ready_d;
    pop_d   = ((state_q == RUN) || (state_q == DRAIN))
              && (fill_q != '0) && pwmBUF_WREADY;
    prime_d = (state_q == PRIME) && en && pwmBUF_WREADY;
    clamp_d = push_d && (s_data > MAXC);
    code_d  = (s_data > MAXC) ? MAXC : s_data;
  end

  // Staging storage; pointers alone define validity
  always_ff @(posedge ACLK) begin
    if (push_d) mem_q[wptr_q] <= code_d;
  end

  // Control FSM, pointers, statistics and registered write port
  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      pcnt_q  <= '0;
      cc_q    <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      wr_q <= 1'b0;
      if (prime_d) begin
        wr_q   <= 1'b1;
        din_q  <= MIDC;
        pcnt_q <= pcnt_q + 16'd1;
      end else if (pop_d) begin
        wr_q   <= 1'b1;
        din_q  <= mute ? MIDC : mem_q[rptr_q];
        rptr_q <= rptr_q + P1;
      end

      if (push_d) wptr_q <= wptr_q + P1;

      if (push_d && !pop_d)      fill_q <= fill_q + F1;
      else if (pop_d && !push_d) fill_q <= fill_q - F1;

      if (clr_stat)
        cc_q <= '0;
      else if (clamp_d && (cc_q != 16'hFFFF))
        cc_q <= cc_q + 16'd1;

      unique case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= PRIME;
            pcnt_q  <= '0;
          end
        end
        PRIME: begin
          if (!en)
            state_q <= IDLE;
          else if (prime_d && (pcnt_q == PLAST))
            state_q <= RUN;
        end
        RUN: begin
          if (!en) state_q <= DRAIN;
        end
        DRAIN: begin
          if (fill_q == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready    = ready_d;
  assign pwmBUF_WR  = wr_q;
  assign pwmBUF_DIN = din_q;
  assign state      = state_q;
  assign fill       = fill_q;
  assign clamp_cnt  = cc_q;

endmodule

// File: tb/tb_pwm_code_writer.sv
// Directed table-driven bench for pwm_code_writer
// with PRIME_CNT=4 and DEPTH=4.
module tb_pwm_code_writer;

  logic        ACLK;
  logic        ARSTN;
  logic        en;
  logic        mute;
  logic        clr_stat;
  logic        s_valid;
  logic [3:0]  s_data;
  logic        s_ready;
  logic        pwmBUF_WREADY;
  logic        pwmBUF_WR;
  logic [3:0]  pwmBUF_DIN;
  logic [1:0]  state;
  logic [2:0]  fill;
  logic [15:0] clamp_cnt;

  int n_chk;
  int n_pass;

  pwm_code_writer #(
    .DEPTH(4),
    .MAX_CODE(12),
    .MID_CODE(6),
    .PRIME_CNT(4)
  ) dut (
    .ACLK(ACLK),
    .ARSTN(ARSTN),
    .en(en),
    .mute(mute),
    .clr_stat(clr_stat),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .pwmBUF_WREADY(pwmBUF_WREADY),
    .pwmBUF_WR(pwmBUF_WR),
    .pwmBUF_DIN(pwmBUF_DIN),
    .state(state),
    .fill(fill),
    .clamp_cnt(clamp_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        en;
    logic        mute;
    logic        clr;
    logic        sv;
    logic [3:0]  sd;
    logic        wrdy;
    logic        wr;
    logic [3:0]  din;
    logic [1:0]  st;
    logic [2:0]  fill;
    logic        rdy;
    logic [15:0] cc;
  } vec_t;

  function automatic vec_t V(
    input logic en_, input logic mu_, input logic cl_,
    input logic sv_, input logic [3:0] sd_, input logic wy_,
    input logic wr_, input logic [3:0] di_, input logic [1:0] st_,
    input logic [2:0] fi_, input logic rd_, input logic [15:0] cc_);
    vec_t r;
    r.en = en_; r.mute = mu_; r.clr = cl_; r.sv = sv_;
    r.sd = sd_; r.wrdy = wy_; r.wr = wr_; r.din = di_;
    r.st = st_; r.fill = fi_; r.rdy = rd_; r.cc = cc_;
    return r;
  endfunction

  task automatic check(input string nm, input vec_t e);
    n_chk++;
    if (pwmBUF_WR === e.wr && pwmBUF_DIN === e.din &&
        state === e.st && fill === e.fill &&
        s_ready === e.rdy && clamp_cnt === e.cc) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got wr=%0b din=%0d st=%0d fill=%0d rdy=%0b cc=%0d want wr=%0b din=%0d st=%0d fill=%0d rdy=%0b cc=%0d",
        nm, pwmBUF_WR, pwmBUF_DIN, state, fill, s_ready, clamp_cnt,
        e.wr, e.din, e.st, e.fill, e.rdy, e.cc);
    end
  endtask

  task automatic apply(input string nm, input vec_t x);
    en            = x.en;
    mute          = x.mute;
    clr_stat      = x.clr;
    s_valid       = x.sv;
    s_data        = x.sd;
    pwmBUF_WREADY = x.wrdy;
    @(posedge ACLK);
    @(negedge ACLK);
    check(nm, x);
  endtask

  vec_t tA[$];
  vec_t tB[$];
  vec_t zero;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    ARSTN = 1'b0;
    en = 1'b0; mute = 1'b0; clr_stat = 1'b0;
    s_valid = 1'b0; s_data = 4'd0; pwmBUF_WREADY = 1'b1;
    zero = V(0,0,0,0,0,0, 0,0,0,0,0,0);

    // prime: 4 writes of 6, then RUN
    tA.push_back(V(1,0,0,0,0,1, 0,0,1,0,0,0));
    for (int i = 0; i < 3; i++)
      tA.push_back(V(1,0,0,0,0,1, 1,6,1,0,0,0));
    tA.push_back(V(1,0,0,0,0,1, 1,6,2,0,1,0));
    // stream 0,5,12,15,9 with clamp
    tA.push_back(V(1,0,0,1,0,1,  0,6,2,1,1,0));
    tA.push_back(V(1,0,0,1,5,1,  1,0,2,1,1,0));
    tA.push_back(V(1,0,0,1,12,1, 1,5,2,1,1,0));
    tA.push_back(V(1,0,0,1,15,1, 1,12,2,1,1,1));
    tA.push_back(V(1,0,0,1,9,1,  1,12,2,1,1,1));
    tA.push_back(V(1,0,0,0,0,1,  1,9,2,0,1,1));
    tA.push_back(V(1,0,0,0,0,1,  0,9,2,0,1,1));
    // WREADY low: fill to 4 and hold
    tA.push_back(V(1,0,0,1,1,0, 0,9,2,1,1,1));
    tA.push_back(V(1,0,0,1,2,0, 0,9,2,2,1,1));
    tA.push_back(V(1,0,0,1,3,0, 0,9,2,3,1,1));
    tA.push_back(V(1,0,0,1,4,0, 0,9,2,4,0,1));
    for (int i = 0; i < 16; i++)
      tA.push_back(V(1,0,0,1,5,0, 0,9,2,4,0,1));
    // WREADY back: staged 1..4 then streaming
    tA.push_back(V(1,0,0,1,10,1, 1,1,2,3,1,1));
    tA.push_back(V(1,0,0,1,10,1, 1,2,2,3,1,1));
    tA.push_back(V(1,0,0,1,11,1, 1,3,2,3,1,1));
    tA.push_back(V(1,0,0,1,2,1,  1,4,2,3,1,1));
    tA.push_back(V(1,0,0,1,3,1,  1,10,2,3,1,1));
    // mute for 3 pops, then next code 7
    tA.push_back(V(1,1,0,1,7,1, 1,6,2,3,1,1));
    tA.push_back(V(1,1,0,1,8,1, 1,6,2,3,1,1));
    tA.push_back(V(1,1,0,1,1,1, 1,6,2,3,1,1));
    tA.push_back(V(1,0,0,1,4,1, 1,7,2,3,1,1));
    // drain 3 staged codes then IDLE
    tA.push_back(V(0,0,0,0,0,1, 1,8,3,2,0,1));
    tA.push_back(V(0,0,0,0,0,1, 1,1,3,1,0,1));
    tA.push_back(V(0,0,0,0,0,1, 1,4,3,0,0,1));
    tA.push_back(V(0,0,0,0,0,1, 0,4,0,0,0,1));
    tA.push_back(V(0,0,0,0,0,1, 0,4,0,0,0,1));
    // prime aborted after 2 writes
    tA.push_back(V(1,0,0,0,0,1, 0,4,1,0,0,1));
    tA.push_back(V(1,0,0,0,0,1, 1,6,1,0,0,1));
    tA.push_back(V(1,0,0,0,0,1, 1,6,1,0,0,1));
    tA.push_back(V(0,0,0,0,0,1, 0,6,0,0,0,1));
    tA.push_back(V(0,0,0,0,0,1, 0,6,0,0,0,1));
    // full prime again, then stage 2 with clear-vs-clamp
    tA.push_back(V(1,0,0,0,0,1, 0,6,1,0,0,1));
    for (int i = 0; i < 3; i++)
      tA.push_back(V(1,0,0,0,0,1, 1,6,1,0,0,1));
    tA.push_back(V(1,0,0,0,0,1,   1,6,2,0,1,1));
    tA.push_back(V(1,0,1,1,13,0,  0,6,2,1,1,0));
    tA.push_back(V(1,0,0,1,14,0,  0,6,2,2,1,1));

    // after mid-RUN reset: prime restarts from zero
    tB.push_back(V(1,0,0,0,0,1, 0,0,1,0,0,0));
    for (int i = 0; i < 3; i++)
      tB.push_back(V(1,0,0,0,0,1, 1,6,1,0,0,0));
    tB.push_back(V(1,0,0,0,0,1, 1,6,2,0,1,0));
    tB.push_back(V(1,0,0,0,0,1, 0,6,2,0,1,0));
    tB.push_back(V(1,0,0,0,0,1, 0,6,2,0,1,0));

    #1;
    check("reset", zero);
    @(negedge ACLK);
    ARSTN = 1'b1;

    foreach (tA[i]) apply($sformatf("A%0d", i), tA[i]);

    // async reset mid-RUN with fill=2
    #2;
    ARSTN = 1'b0;
    #1;
    check("async_rst", zero);
    @(negedge ACLK);
    check("rst_hold", zero);
    ARSTN = 1'b1;

    foreach (tB[i]) apply($sformatf("B%0d", i), tB[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
